collision_event_arbiter: RTL and testbench

- Parametrised successor to the per-frame collision controller for the billiard table.
- Watches per-pixel drawing requests (balls, table cushions, holes) and classifies each overlap as ball-hole, ball-ball or ball-wall.
- Deduplicates events within a frame and queues them in a small FIFO as typed event records; the ball-physics block pops them with a valid/ready handshake.
- Sits between the VGA object drawers and the ball-move/physics blocks; also owns the balls-in-game mask.

---
 rtl/collision_pkg.sv | 42 ++++
 rtl/collision_event_fifo.sv | 63 ++++++
 rtl/collision_event_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_collision_event_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and bit-scan helpers for the collision event arbiter.
// The record widths cover the largest legal table (32 balls); narrower builds truncate.
package collision_pkg;

    localparam int MAX_BALLS = 32;
    localparam int MAX_ID_W  = 5;

    localparam logic [1:0] WALL_NONE = 2'b00;

    typedef enum logic [1:0] {
        EVT_NONE = 2'b00,
        EVT_HOLE = 2'b01,
        EVT_BALL = 2'b10,
        EVT_WALL = 2'b11
    } evt_type_t;

    typedef struct packed {
        evt_type_t             evt_type;
        logic [MAX_ID_W-1:0]   id_a;
        logic [MAX_ID_W-1:0]   id_b;
        logic [1:0]            wall;
    } collision_evt_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [MAX_ID_W-1:0] lowest_set_bit(input logic [MAX_BALLS-1:0] vec);
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_BALLS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = MAX_ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_ID_W-1:0] second_set_bit(input logic [MAX_BALLS-1:0] vec);
        return lowest_set_bit(vec & (vec - 32'd1));
    endfunction

endpackage

// File: rtl/collision_event_fifo.sv
// Event record FIFO with first-word-fall-through head and a synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module collision_event_fifo
    import collision_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter type T      = collision_evt_t,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  T                 data_i,
    input  logic             pop_i,
    output T                 data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == CNT_W'(0));
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign data_o    = empty_o ? T'('0) : mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_q <= do_pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            count_q  <= count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Storage array; contents are never observable while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: rtl/collision_event_arbiter.sv
// Classifies per-pixel ball/hole/cushion overlaps into deduplicated events and queues them.
// Optional per-frame statistics outputs are enabled by defining COLLISION_STATS_EN.
module collision_event_arbiter
    import collision_pkg::*;
#(
    parameter int  NUM_BALLS  = 16,
    parameter int  FIFO_DEPTH = 8,
    localparam int ID_W       = $clog2(NUM_BALLS)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 newGame,
    input  logic [NUM_BALLS-1:0] Balls_DR_VEC,
    input  logic [1:0]           Table_DR,
    input  logic                 Hole_DR,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [1:0]           evt_type,
    output logic [ID_W-1:0]      evt_id_a,
    output logic [ID_W-1:0]      evt_id_b,
    output logic [1:0]           evt_wall,
    output logic [NUM_BALLS-1:0] balls_in_game,
`ifdef COLLISION_STATS_EN
    output logic [7:0]           stat_evt_cnt,
    output logic [7:0]           stat_drop_cnt,
`endif
    output logic                 frame_done,
    output logic                 overflow
);

    localparam logic [0:0] S_WAIT    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;
    localparam int         CNT_W     = $clog2(FIFO_DEPTH) + 1;

    logic [0:0]           state_q, state_d;
    logic [NUM_BALLS-1:0] in_game_q, in_game_d;
    logic [NUM_BALLS-1:0] wall_hit_q, wall_hit_d;
    logic                 pair_vld_q, pair_vld_d;
    logic [ID_W-1:0]      pair_a_q, pair_a_d, pair_b_q, pair_b_d;
    logic                 overflow_q, overflow_d;
    logic                 frame_done_q;

    logic [NUM_BALLS-1:0] masked_s;
    logic [MAX_BALLS-1:0] masked_ext_s;
    logic [MAX_ID_W-1:0]  lo_s, hi_s;
    logic [ID_W-1:0]      lo_id_s, hi_id_s;
    logic                 collect_s, sof_clear_s, any_s, multi_s;
    logic                 hole_cand_s, ball_cand_s, wall_cand_s, push_s;
    logic                 fifo_full_s, fifo_empty_s, pop_s, drop_s;
    logic [CNT_W-1:0]     fifo_count_s;
    collision_evt_t       evt_s, head_s;
    logic                 unused_s;

    assign masked_s    = Balls_DR_VEC & in_game_q;
    assign collect_s   = (state_q == S_COLLECT) && !newGame;
    assign sof_clear_s = collect_s && startOfFrame;
    assign lo_s        = lowest_set_bit(masked_ext_s);
    assign hi_s        = second_set_bit(masked_ext_s);
    assign lo_id_s     = lo_s[ID_W-1:0];
    assign hi_id_s     = hi_s[ID_W-1:0];
    assign any_s       = |masked_ext_s;
    assign multi_s     = |(masked_ext_s & (masked_ext_s - 32'd1));

    // Zero-extend the live ball mask to the width the bit-scan helpers expect.
    always_comb begin
        masked_ext_s                = '0;
        masked_ext_s[NUM_BALLS-1:0] = masked_s;
    end

    // Frame-start clearing takes effect before this pixel's candidates are judged.
    always_comb begin
        wall_hit_d  = sof_clear_s ? '0   : wall_hit_q;
        pair_vld_d  = sof_clear_s ? 1'b0 : pair_vld_q;
        pair_a_d    = pair_a_q;
        pair_b_d    = pair_b_q;
        in_game_d   = in_game_q;
        hole_cand_s = collect_s && Hole_DR && any_s;
        ball_cand_s = collect_s && multi_s &&
                      !(pair_vld_d && (pair_a_q == lo_id_s) && (pair_b_q == hi_id_s));
        wall_cand_s = collect_s && (Table_DR != WALL_NONE) && any_s && !wall_hit_d[lo_id_s];
        evt_s       = '{evt_type: EVT_NONE, id_a: '0, id_b: '0, wall: WALL_NONE};
        if (hole_cand_s) begin
            evt_s.evt_type     = EVT_HOLE;
            evt_s.id_a         = lo_s;
            in_game_d[lo_id_s] = 1'b0;
        end else if (ball_cand_s) begin
            evt_s.evt_type = EVT_BALL;
            evt_s.id_a     = lo_s;
            evt_s.id_b     = hi_s;
            pair_vld_d     = 1'b1;
            pair_a_d       = lo_id_s;
            pair_b_d       = hi_id_s;
        end else if (wall_cand_s) begin
            evt_s.evt_type      = EVT_WALL;
            evt_s.id_a          = lo_s;
            evt_s.wall          = Table_DR;
            wall_hit_d[lo_id_s] = 1'b1;
        end else begin
            evt_s.evt_type = EVT_NONE;
        end
        push_s     = hole_cand_s || ball_cand_s || wall_cand_s;
        pop_s      = !fifo_empty_s && evt_ready;
        drop_s     = push_s && fifo_full_s && !pop_s;
        overflow_d = overflow_q || drop_s;
    end

    // Frame sequencing: nothing is collected until the first frame start.
    always_comb begin
        case (state_q)
            S_WAIT:    state_d = startOfFrame ? S_COLLECT : S_WAIT;
            S_COLLECT: state_d = S_COLLECT;
            default:   state_d = S_WAIT;
        endcase
    end

    // Game and per-frame bookkeeping; newGame overrides everything else.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_WAIT;
            in_game_q    <= '1;
            wall_hit_q   <= '0;
            pair_vld_q   <= 1'b0;
            pair_a_q     <= '0;
            pair_b_q     <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (newGame) begin
            state_q      <= S_WAIT;
            in_game_q    <= '1;
            wall_hit_q   <= '0;
            pair_vld_q   <= 1'b0;
            pair_a_q     <= '0;
            pair_b_q     <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_game_q    <= in_game_d;
            wall_hit_q   <= wall_hit_d;
            pair_vld_q   <= pair_vld_d;
            pair_a_q     <= pair_a_d;
            pair_b_q     <= pair_b_d;
            overflow_q   <= overflow_d;
            frame_done_q <= sof_clear_s;
        end
    end

    collision_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (collision_evt_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (resetN),
        .flush_i (newGame),
        .push_i  (push_s),
        .data_i  (evt_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

`ifdef COLLISION_STATS_EN
    logic [7:0] evt_cnt_q, drop_cnt_q, stat_evt_q, stat_drop_q;
    logic       accept_s;

    assign accept_s = push_s && !drop_s;

    // Per-frame counters, snapshotted at each frame boundary and saturating at 255.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            evt_cnt_q   <= 8'd0;
            drop_cnt_q  <= 8'd0;
            stat_evt_q  <= 8'd0;
            stat_drop_q <= 8'd0;
        end else if (newGame) begin
            evt_cnt_q   <= 8'd0;
            drop_cnt_q  <= 8'd0;
            stat_evt_q  <= stat_evt_q;
            stat_drop_q <= stat_drop_q;
        end else if (sof_clear_s) begin
            stat_evt_q  <= evt_cnt_q;
            stat_drop_q <= drop_cnt_q;
            evt_cnt_q   <= {7'd0, accept_s};
            drop_cnt_q  <= {7'd0, drop_s};
        end else begin
            stat_evt_q  <= stat_evt_q;
            stat_drop_q <= stat_drop_q;
            evt_cnt_q   <= (accept_s && evt_cnt_q != 8'hFF)  ? evt_cnt_q + 8'd1  : evt_cnt_q;
            drop_cnt_q  <= (drop_s && drop_cnt_q != 8'hFF)   ? drop_cnt_q + 8'd1 : drop_cnt_q;
        end
    end

    assign stat_evt_cnt  = stat_evt_q;
    assign stat_drop_cnt = stat_drop_q;
`endif

    assign evt_valid     = !fifo_empty_s;
    assign evt_type      = head_s.evt_type;
    assign evt_id_a      = head_s.id_a[ID_W-1:0];
    assign evt_id_b      = head_s.id_b[ID_W-1:0];
    assign evt_wall      = head_s.wall;
    assign balls_in_game = in_game_q;
    assign frame_done    = frame_done_q;
    assign overflow      = overflow_q;
    assign unused_s      = &{1'b0, head_s, lo_s, hi_s, fifo_count_s};

endmodule

// File: tb/tb_collision_event_arbiter.sv
// Scoreboard bench: stimulus queues hand-computed event records, a negedge monitor
// compares every handshaken FIFO head against them.
module tb_collision_event_arbiter;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame, newGame, Hole_DR, evt_ready;
    logic [15:0] Balls_DR_VEC;
    logic [1:0]  Table_DR;
    logic        evt_valid, frame_done, overflow;
    logic [1:0]  evt_type, evt_wall;
    logic [3:0]  evt_id_a, evt_id_b;
    logic [15:0] balls_in_game;
`ifdef COLLISION_STATS_EN
    logic [7:0]  stat_evt_cnt, stat_drop_cnt;
`endif

    logic [11:0] exp_q [$];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    collision_event_arbiter #(.NUM_BALLS(16), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .newGame       (newGame),
        .Balls_DR_VEC  (Balls_DR_VEC),
        .Table_DR      (Table_DR),
        .Hole_DR       (Hole_DR),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_type      (evt_type),
        .evt_id_a      (evt_id_a),
        .evt_id_b      (evt_id_b),
        .evt_wall      (evt_wall),
        .balls_in_game (balls_in_game),
`ifdef COLLISION_STATS_EN
        .stat_evt_cnt  (stat_evt_cnt),
        .stat_drop_cnt (stat_drop_cnt),
`endif
        .frame_done    (frame_done),
        .overflow      (overflow)
    );

    function automatic logic [11:0] mk(input logic [1:0] t, input logic [3:0] a,
                                       input logic [3:0] b, input logic [1:0] w);
        return {t, a, b, w};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    task automatic step(input logic sof, input logic ng, input logic [15:0] balls,
                        input logic [1:0] tbl, input logic hole);
        startOfFrame = sof;
        newGame      = ng;
        Balls_DR_VEC = balls;
        Table_DR     = tbl;
        Hole_DR      = hole;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        newGame      = 1'b0;
        Balls_DR_VEC = 16'h0000;
        Table_DR     = 2'b00;
        Hole_DR      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
    endtask

    // Monitor: every accepted head must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetN && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_evt: got 0x%0h, expected no event",
                         {evt_type, evt_id_a, evt_id_b, evt_wall});
            end else begin
                chk("evt", {20'd0, evt_type, evt_id_a, evt_id_b, evt_wall}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0; newGame = 1'b0; Hole_DR = 1'b0; evt_ready = 1'b0;
        Balls_DR_VEC = 16'h0000; Table_DR = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_in_game", balls_in_game, 16'hFFFF);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        resetN = 1'b1;

        // Ball-ball dedup within a frame, retrigger after frame start.
        step(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0);
        chk("first_sof_no_done", frame_done, 0);
        exp_q.push_back(mk(2'b10, 4'd1, 4'd2, 2'b00));
        step(1'b0, 1'b0, 16'h0006, 2'b00, 1'b0);
        chk("push_latency", evt_valid, 1);
        repeat (5) step(1'b0, 1'b0, 16'h0006, 2'b00, 1'b0);
        evt_ready = 1'b1;
        idle(2);
        chk("pair_dedup_single", evt_valid, 0);
        exp_q.push_back(mk(2'b10, 4'd1, 4'd2, 2'b00));
        step(1'b1, 1'b0, 16'h0006, 2'b00, 1'b0);
        chk("frame_done_pulse", frame_done, 1);
        idle(1);
        chk("frame_done_one_cycle", frame_done, 0);

        // Pocketing: ball 3 disappears from every later classification.
        exp_q.push_back(mk(2'b01, 4'd3, 4'd0, 2'b00));
        step(1'b0, 1'b0, 16'h0008, 2'b00, 1'b1);
        chk("in_game_after_hole", balls_in_game, 16'hFFF7);
        step(1'b0, 1'b0, 16'h000C, 2'b00, 1'b0);
        step(1'b0, 1'b0, 16'h0008, 2'b01, 1'b0);
        step(1'b0, 1'b0, 16'h0008, 2'b00, 1'b1);

        // Wall dedup is per ball regardless of wall code.
        exp_q.push_back(mk(2'b11, 4'd0, 4'd0, 2'b10));
        repeat (3) step(1'b0, 1'b0, 16'h0001, 2'b10, 1'b0);
        step(1'b0, 1'b0, 16'h0001, 2'b01, 1'b0);

        // Priority: hole wins and the lower classes are discarded.
        exp_q.push_back(mk(2'b01, 4'd4, 4'd0, 2'b00));
        step(1'b0, 1'b0, 16'h0030, 2'b01, 1'b1);
        chk("in_game_two_pocketed", balls_in_game, 16'hFFE7);
        exp_q.push_back(mk(2'b11, 4'd5, 4'd0, 2'b01));
        step(1'b0, 1'b0, 16'h0030, 2'b01, 1'b0);

        // Only the most recent pair is remembered.
        exp_q.push_back(mk(2'b10, 4'd0, 4'd1, 2'b00));
        step(1'b0, 1'b0, 16'h0003, 2'b00, 1'b0);
        exp_q.push_back(mk(2'b10, 4'd1, 4'd2, 2'b00));
        step(1'b0, 1'b0, 16'h0006, 2'b00, 1'b0);
        idle(4);
        chk("drained", evt_valid, 0);
        chk("no_overflow_yet", overflow, 0);

        // Overflow: nine distinct wall hits into an 8-deep FIFO, then push while full with a pop.
        step(1'b0, 1'b1, 16'h0000, 2'b00, 1'b0);
        chk("newgame_in_game", balls_in_game, 16'hFFFF);
        step(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0);
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(mk(2'b11, 4'(i), 4'd0, 2'b01));
            step(1'b0, 1'b0, 16'd1 << i, 2'b01, 1'b0);
        end
        chk("overflow_set", overflow, 1);
        chk("full_valid", evt_valid, 1);
        evt_ready = 1'b1;
        exp_q.push_back(mk(2'b11, 4'd9, 4'd0, 2'b01));
        step(1'b0, 1'b0, 16'h0200, 2'b01, 1'b0);
        idle(12);
        chk("overflow_sticky", overflow, 1);
        chk("overflow_drained", evt_valid, 0);

        // newGame mid-frame flushes queued events and waits for the next frame.
        evt_ready = 1'b0;
        step(1'b0, 1'b0, 16'h0400, 2'b01, 1'b0);
        step(1'b0, 1'b0, 16'h0800, 2'b01, 1'b0);
        step(1'b0, 1'b0, 16'h1000, 2'b01, 1'b0);
        chk("queued_before_ng", evt_valid, 1);
        step(1'b0, 1'b1, 16'h0000, 2'b00, 1'b0);
        chk("ng_flush", evt_valid, 0);
        chk("ng_overflow_clr", overflow, 0);
        evt_ready = 1'b1;
        step(1'b0, 1'b0, 16'h0006, 2'b00, 1'b0);
        idle(2);
        chk("wait_ignores", evt_valid, 0);
        step(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0);
        chk("sof_after_ng_no_done", frame_done, 0);
        exp_q.push_back(mk(2'b10, 4'd1, 4'd2, 2'b00));
        step(1'b0, 1'b0, 16'h0006, 2'b00, 1'b0);
        idle(3);

        // Asynchronous reset mid-operation discards queued content.
        evt_ready = 1'b0;
        step(1'b0, 1'b0, 16'h0003, 2'b00, 1'b0);
        chk("queued_before_rst", evt_valid, 1);
        #2 resetN = 1'b0;
        #1;
        chk("rst_mid_valid", evt_valid, 0);
        chk("rst_mid_type", evt_type, 0);
        @(posedge clk);
        #1 resetN = 1'b1;
        evt_ready = 1'b1;
        idle(3);
        chk("post_rst_idle", evt_valid, 0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
